cpu_loader: RTL and testbench



---
 rtl/cpu_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_cpu_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_loader.sv
// ---------------------------------------------------------------------------
// cpu_loader
//
// Program loader and run sequencer for the `cpu` core. A byte stream fills
// data RAM first (one byte per RAM word) and then instruction ROM (two bytes
// per word, low byte first). The core is then released from reset, allowed
// to run until it reports idle (or a cycle limit expires) and is finally
// parked back in reset.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           begin a load+run session (only looked at in IDLE)
//   in_valid/ready  byte stream handshake, in_data is the byte
//   ram_we/addr/wdata  registered RAM write port
//   rom_we/addr/wdata  registered ROM write port
//   cpu_rstn        low holds the core in reset
//   cpu_setn        run enable for the core
//   cpu_idle        core reports it has reached an idle instruction
//   busy            high whenever the FSM is not in IDLE
//   done            one-cycle pulse when a session ends
//   timeout         sticky run-abort flag, cleared by the next start
//   run_cycles      cycles spent in RUN, saturating
//   fsm_state       current FSM state, for observation only
//
// Handshake: a byte is transferred on every rising edge where in_valid and
// in_ready are both high. in_ready depends on the FSM state only, never on
// in_valid; the source must hold in_data stable while in_valid is high and
// the byte has not yet been taken.
// ---------------------------------------------------------------------------
module cpu_loader #(
    parameter int IMSB    = 15,
    parameter int PMSB    = 7,
    parameter int AMSB    = 7,
    parameter int DMSB    = 7,
    parameter int RUN_MAX = 65535
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            ram_we,
    output logic [AMSB:0]   ram_addr,
    output logic [DMSB:0]   ram_wdata,
    output logic            rom_we,
    output logic [PMSB:0]   rom_addr,
    output logic [IMSB:0]   rom_wdata,
    output logic            cpu_rstn,
    output logic            cpu_setn,
    input  logic            cpu_idle,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [15:0]     run_cycles,
    output logic [2:0]      fsm_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LD_RAM    = 3'd1,
        LD_ROM_LO = 3'd2,
        LD_ROM_HI = 3'd3,
        ARM       = 3'd4,
        RUN       = 3'd5,
        DRAIN     = 3'd6
    } state_t;

    localparam logic [AMSB:0] RAM_LAST = '1;
    localparam logic [PMSB:0] ROM_LAST = '1;
    localparam logic [15:0]   RUN_LAST = 16'(RUN_MAX - 1);
    localparam logic [15:0]   RUN_SAT  = 16'hFFFF;

    state_t        state;
    state_t        state_next;
    logic [AMSB:0] ram_cnt;
    logic [PMSB:0] rom_cnt;
    logic [7:0]    rom_lo;
    logic          phase;     // second cycle of the two-cycle ARM/DRAIN windows
    logic          accept;
    logic          run_hit_max;
    logic          idle_armed;

    assign accept      = in_valid && in_ready;
    // run_cycles still holds the count of completed RUN cycles, so the
    // current cycle is the RUN_MAX-th one when it equals RUN_MAX-1.
    assign run_hit_max = (run_cycles == RUN_LAST);
    // The core shows inst=0 before its first fetch, so idle is only trusted
    // from the third RUN cycle onwards.
    assign idle_armed  = (run_cycles >= 16'd2);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = LD_RAM;
            end
            LD_RAM: begin
                if (accept && ram_cnt == RAM_LAST) state_next = LD_ROM_LO;
            end
            LD_ROM_LO: begin
                if (accept) state_next = LD_ROM_HI;
            end
            LD_ROM_HI: begin
                if (accept) state_next = (rom_cnt == ROM_LAST) ? ARM : LD_ROM_LO;
            end
            ARM: begin
                if (phase) state_next = RUN;
            end
            RUN: begin
                // Reaching the cycle limit ends the run even if idle shows up
                // in the same cycle.
                if (run_hit_max || (idle_armed && cpu_idle)) state_next = DRAIN;
            end
            DRAIN: begin
                if (phase) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        busy      = (state != IDLE);
        cpu_rstn  = 1'b0;
        cpu_setn  = 1'b0;
        fsm_state = state;
        case (state)
            LD_RAM, LD_ROM_LO, LD_ROM_HI: in_ready = 1'b1;
            ARM, DRAIN:                   cpu_rstn = 1'b1;
            RUN: begin
                cpu_rstn = 1'b1;
                cpu_setn = 1'b1;
            end
            default: ;
        endcase
        // A reset pulse puts the core back in reset in the same cycle
        // rather than waiting for the state register to clear.
        if (rst) begin
            cpu_rstn = 1'b0;
            cpu_setn = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: counters, write ports, run bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_cnt    <= '0;
            rom_cnt    <= '0;
            rom_lo     <= '0;
            phase      <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdata  <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            run_cycles <= '0;
        end else begin
            ram_we <= 1'b0;
            rom_we <= 1'b0;
            done   <= 1'b0;
            phase  <= ((state == ARM) || (state == DRAIN)) && !phase;

            case (state)
                IDLE: begin
                    if (start) begin
                        ram_cnt    <= '0;
                        rom_cnt    <= '0;
                        run_cycles <= '0;
                        timeout    <= 1'b0;
                    end
                end
                LD_RAM: begin
                    if (accept) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= ram_cnt;
                        ram_wdata <= in_data;
                        ram_cnt   <= (ram_cnt == RAM_LAST) ? '0 : ram_cnt + 1'b1;
                    end
                end
                LD_ROM_LO: begin
                    if (accept) rom_lo <= in_data;
                end
                LD_ROM_HI: begin
                    if (accept) begin
                        rom_we    <= 1'b1;
                        rom_addr  <= rom_cnt;
                        rom_wdata <= {in_data, rom_lo};
                        rom_cnt   <= (rom_cnt == ROM_LAST) ? '0 : rom_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (run_cycles != RUN_SAT) run_cycles <= run_cycles + 16'd1;
                    if (run_hit_max) timeout <= 1'b1;
                end
                DRAIN: begin
                    // done lands in the first IDLE cycle, where cpu_rstn is
                    // already low again.
                    if (phase) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_loader.sv
// ---------------------------------------------------------------------------
// tb_cpu_loader
//
// Directed bench for cpu_loader with RUN_MAX reduced to 20. The core is
// modelled by a small counter: cpu_idle rises once cpu_setn has been high
// for idle_at cycles, so each scenario picks how long the program "runs".
// ---------------------------------------------------------------------------
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        rom_we;
    logic [7:0]  rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_rstn;
    logic        cpu_setn;
    logic        cpu_idle;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] run_cycles;
    logic [2:0]  fsm_state;

    int tests = 0;
    int fails = 0;

    // core model
    int idle_at  = 1000;
    int setn_cnt = 0;

    // stream contents: 256 RAM bytes then 256 ROM words, low byte first
    logic [7:0]  stream [768];

    // monitor state
    logic        mon_clear = 1'b0;
    logic [15:0] ram_log[$];
    logic [23:0] rom_log[$];
    logic [23:0] exp_q[$];
    int          bad_strobe = 0;
    int          setn_hi    = 0;
    int          rstn_only  = 0;
    int          done_cnt   = 0;
    int          done_bad   = 0;
    logic        prev_acc   = 1'b0;

    cpu_loader #(
        .IMSB(15), .PMSB(7), .AMSB(7), .DMSB(7), .RUN_MAX(20)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_rstn(cpu_rstn), .cpu_setn(cpu_setn), .cpu_idle(cpu_idle),
        .busy(busy), .done(done), .timeout(timeout),
        .run_cycles(run_cycles), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset-independent models ----------------
    always #5 clk = ~clk;

    always @(posedge clk) setn_cnt <= cpu_setn ? setn_cnt + 1 : 0;
    assign cpu_idle = cpu_setn && (setn_cnt >= idle_at);

    always @(negedge clk) begin
        if (mon_clear) begin
            ram_log.delete();
            rom_log.delete();
            bad_strobe = 0;
            setn_hi    = 0;
            rstn_only  = 0;
            done_cnt   = 0;
            done_bad   = 0;
        end
        if (ram_we) begin
            ram_log.push_back({ram_addr, ram_wdata});
            if (!prev_acc) bad_strobe++;
        end
        if (rom_we) begin
            rom_log.push_back({rom_addr, rom_wdata});
            if (!prev_acc) bad_strobe++;
        end
        if (cpu_setn) setn_hi++;
        if (cpu_rstn && !cpu_setn) rstn_only++;
        if (done) begin
            done_cnt++;
            if (cpu_rstn || busy) done_bad++;
        end
        prev_acc = in_valid && in_ready;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // All drivers are entered and left at posedge+1.
    task automatic start_session();
        mon_clear = 1'b1;
        @(posedge clk); #1;
        mon_clear = 1'b0;
        start     = 1'b1;
        in_valid  = 1'b1;       // offered in IDLE, must not be taken
        in_data   = 8'hEE;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic feed(input int nbytes, input bit throttle, output int fed);
        int   cyc;
        logic rdy;
        cyc = 0;
        fed = 0;
        while (fed < nbytes && cyc < 6000) begin
            in_data  = stream[fed];
            in_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) fed++;
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_session(input bit throttle);
        int fed;
        bit ok;
        start_session();
        feed(768, throttle, fed);
        wait_done(ok);
        tests++;
        if (!ok || fed != 768) begin
            fails++;
            $display("FAIL session_complete: fed=%0d done_seen=%0d, need fed=768 done_seen=1", fed, ok);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        tests++; if (in_ready !== 1'b0)    begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        tests++; if (ram_we !== 1'b0)      begin fails++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        tests++; if (rom_we !== 1'b0)      begin fails++; $display("FAIL rst_rom_we: got %b want 0", rom_we); end
        tests++; if (ram_addr !== 8'h00 || ram_wdata !== 8'h00) begin fails++; $display("FAIL rst_ram_bus: got %h/%h want 00/00", ram_addr, ram_wdata); end
        tests++; if (rom_addr !== 8'h00 || rom_wdata !== 16'h0000) begin fails++; $display("FAIL rst_rom_bus: got %h/%h want 00/0000", rom_addr, rom_wdata); end
        tests++; if (cpu_rstn !== 1'b0 || cpu_setn !== 1'b0) begin fails++; $display("FAIL rst_cpu: got rstn=%b setn=%b want 0/0", cpu_rstn, cpu_setn); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_busy_done: got %b/%b want 0/0", busy, done); end
        tests++; if (timeout !== 1'b0)     begin fails++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        tests++; if (run_cycles !== 16'd0) begin fails++; $display("FAIL rst_run_cycles: got %0d want 0", run_cycles); end
        tests++; if (fsm_state !== 3'd0)   begin fails++; $display("FAIL rst_state: got %0d want 0", fsm_state); end
        // IDLE offers no ready even with a byte pending
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h33;
        @(negedge clk); #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); #1;
        tests++; if (ram_we !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL idle_no_write: got we=%b busy=%b want 0/0", ram_we, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_load();
        logic [23:0] exp;
        idle_at = 5;
        do_session(1'b0);
        tests++; if (ram_log.size() != 256) begin fails++; $display("FAIL full_ram_count: got %0d want 256", ram_log.size()); end
        for (int k = 0; k < ram_log.size(); k++) begin
            tests++;
            if (ram_log[k] !== {8'(k), 8'(k) ^ 8'h5A}) begin fails++; $display("FAIL full_ram_%0d: got %h want %h", k, ram_log[k], {8'(k), 8'(k) ^ 8'h5A}); end
        end
        exp_q.delete();
        for (int j = 0; j < 256; j++) exp_q.push_back({8'(j), 16'h8000 | 16'(j)});
        tests++; if (rom_log.size() != 256) begin fails++; $display("FAIL full_rom_count: got %0d want 256", rom_log.size()); end
        for (int j = 0; j < rom_log.size(); j++) begin
            exp = exp_q.pop_front();
            tests++;
            if (rom_log[j] !== exp) begin fails++; $display("FAIL full_rom_%0d: got %h want %h", j, rom_log[j], exp); end
        end
        tests++; if (bad_strobe != 0) begin fails++; $display("FAIL full_stray_strobe: got %0d want 0", bad_strobe); end
        // run-to-idle: idle after 5 setn cycles -> RUN lasts 6 cycles
        tests++; if (setn_hi != 6)        begin fails++; $display("FAIL run_setn_cycles: got %0d want 6", setn_hi); end
        tests++; if (run_cycles !== 16'd6) begin fails++; $display("FAIL run_cycles: got %0d want 6", run_cycles); end
        tests++; if (timeout !== 1'b0)    begin fails++; $display("FAIL run_timeout: got %b want 0", timeout); end
        tests++; if (rstn_only != 4)      begin fails++; $display("FAIL run_arm_drain: got %0d want 4", rstn_only); end
        tests++; if (done_cnt != 1 || done_bad != 0) begin fails++; $display("FAIL run_done: got pulses=%0d bad=%0d want 1/0", done_cnt, done_bad); end
    endtask

    task automatic test_throttled();
        logic [23:0] exp;
        idle_at = 5;
        do_session(1'b1);
        tests++; if (ram_log.size() != 256) begin fails++; $display("FAIL thr_ram_count: got %0d want 256", ram_log.size()); end
        for (int k = 0; k < ram_log.size(); k++) begin
            tests++;
            if (ram_log[k] !== {8'(k), 8'(k) ^ 8'h5A}) begin fails++; $display("FAIL thr_ram_%0d: got %h want %h", k, ram_log[k], {8'(k), 8'(k) ^ 8'h5A}); end
        end
        exp_q.delete();
        for (int j = 0; j < 256; j++) exp_q.push_back({8'(j), 16'h8000 | 16'(j)});
        tests++; if (rom_log.size() != 256) begin fails++; $display("FAIL thr_rom_count: got %0d want 256", rom_log.size()); end
        for (int j = 0; j < rom_log.size(); j++) begin
            exp = exp_q.pop_front();
            tests++;
            if (rom_log[j] !== exp) begin fails++; $display("FAIL thr_rom_%0d: got %h want %h", j, rom_log[j], exp); end
        end
        tests++; if (bad_strobe != 0) begin fails++; $display("FAIL thr_stray_strobe: got %0d want 0", bad_strobe); end
    endtask

    task automatic test_early_idle();
        idle_at = 0;    // idle from the very first RUN cycle
        do_session(1'b0);
        tests++; if (setn_hi != 3)         begin fails++; $display("FAIL early_setn_cycles: got %0d want 3", setn_hi); end
        tests++; if (run_cycles !== 16'd3) begin fails++; $display("FAIL early_run_cycles: got %0d want 3", run_cycles); end
        tests++; if (rstn_only != 4)       begin fails++; $display("FAIL early_arm_drain: got %0d want 4", rstn_only); end
        tests++; if (done_cnt != 1 || timeout !== 1'b0) begin fails++; $display("FAIL early_done: got pulses=%0d timeout=%b want 1/0", done_cnt, timeout); end
    endtask

    task automatic test_timeout();
        idle_at = 1000;
        do_session(1'b0);
        tests++; if (timeout !== 1'b1)      begin fails++; $display("FAIL to_flag: got %b want 1", timeout); end
        tests++; if (run_cycles !== 16'd20) begin fails++; $display("FAIL to_run_cycles: got %0d want 20", run_cycles); end
        tests++; if (setn_hi != 20)         begin fails++; $display("FAIL to_setn_cycles: got %0d want 20", setn_hi); end
        tests++; if (done_cnt != 1 || done_bad != 0) begin fails++; $display("FAIL to_done: got pulses=%0d bad=%0d want 1/0", done_cnt, done_bad); end
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk); #1;
        tests++; if (timeout !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL to_sticky: got timeout=%b busy=%b want 1/0", timeout, busy); end
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        tests++; if (timeout !== 1'b0 || run_cycles !== 16'd0) begin fails++; $display("FAIL to_clear_on_start: got timeout=%b run=%0d want 0/0", timeout, run_cycles); end
        tests++; if (busy !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL to_restart_load: got busy=%b ready=%b want 1/1", busy, in_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int fed;
        idle_at = 5;
        start_session();
        feed(100, 1'b0, fed);
        in_data  = stream[100];
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk); #1;
        tests++; if (busy !== 1'b0 || fsm_state !== 3'd0 || in_ready !== 1'b0) begin fails++; $display("FAIL midrst_idle: got busy=%b state=%0d ready=%b want 0/0/0", busy, fsm_state, in_ready); end
        tests++; if (ram_we !== 1'b0 || ram_addr !== 8'h00 || ram_wdata !== 8'h00) begin fails++; $display("FAIL midrst_ram_port: got we=%b %h/%h want 0 00/00", ram_we, ram_addr, ram_wdata); end
        tests++; if (ram_log.size() != 100) begin fails++; $display("FAIL midrst_ram_count: got %0d want 100", ram_log.size()); end
        tests++; if (cpu_rstn !== 1'b0 || cpu_setn !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrst_cpu: got %b/%b/%b want 0/0/0", cpu_rstn, cpu_setn, done); end
        @(posedge clk); #1;
        do_session(1'b0);
        tests++; if (ram_log.size() != 256) begin fails++; $display("FAIL reload_ram_count: got %0d want 256", ram_log.size()); end
        if (ram_log.size() > 100) begin
            tests++; if (ram_log[0] !== 16'h005A)   begin fails++; $display("FAIL reload_first: got %h want 005a", ram_log[0]); end
            tests++; if (ram_log[100] !== 16'h643E) begin fails++; $display("FAIL reload_100: got %h want 643e", ram_log[100]); end
        end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL reload_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid_run();
        int fed;
        bit in_run;
        idle_at = 1000;
        start_session();
        feed(768, 1'b0, fed);
        in_run = 1'b0;
        for (int i = 0; i < 20 && !in_run; i++) begin
            @(negedge clk);
            if (cpu_setn) in_run = 1'b1;
        end
        tests++; if (!in_run) begin fails++; $display("FAIL runrst_reach_run: got setn never high want high"); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++; if (cpu_rstn !== 1'b0 || cpu_setn !== 1'b0) begin fails++; $display("FAIL runrst_immediate: got rstn=%b setn=%b want 0/0", cpu_rstn, cpu_setn); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        tests++; if (busy !== 1'b0 || run_cycles !== 16'd0 || done !== 1'b0) begin fails++; $display("FAIL runrst_idle: got busy=%b run=%0d done=%b want 0/0/0", busy, run_cycles, done); end
        tests++; if (cpu_rstn !== 1'b0 || cpu_setn !== 1'b0) begin fails++; $display("FAIL runrst_parked: got %b/%b want 0/0", cpu_rstn, cpu_setn); end
        @(posedge clk); #1;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int k = 0; k < 256; k++) stream[k] = 8'(k) ^ 8'h5A;
        for (int j = 0; j < 256; j++) begin
            stream[256 + 2 * j]     = 8'(j);
            stream[256 + 2 * j + 1] = 8'h80;
        end

        test_reset();
        test_full_load();
        test_throttled();
        test_early_idle();
        test_timeout();
        test_reset_mid_load();
        test_reset_mid_run();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
